// File: rtl/pipeline_control_pkg.sv
// Shared types and stage indices for the in-order core pipeline sequencer.
package pipeline_control_pkg;

  localparam int STAGE_IF  = 0;
  localparam int STAGE_ID  = 1;
  localparam int STAGE_EX  = 2;
  localparam int STAGE_MEM = 3;
  localparam int STAGE_WB  = 4;

  localparam int DEF_NUM_STAGES = STAGE_WB + 1;

  typedef logic [DEF_NUM_STAGES-1:0] StageMask;

endpackage

// File: rtl/pipeline_control_event_counter.sv
// Free-running wrap-around event counter with enable and async active-high reset.
module event_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  output logic [CNT_WIDTH-1:0] o_count
);

  localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_enable) count_d = count_q + ONE;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) count_q <= '0;
    else         count_q <= count_d;
  end

  assign o_count = count_q;

endmodule

// File: rtl/pipeline_control.sv
// Per-stage valid tracking and hold/bubble/flush sequencing for the in-order pipeline,
// plus cycle and retired-instruction counters for the debug controller.
module pipeline_control
  import pipeline_control_pkg::*;
#(
  parameter int NUM_STAGES     = DEF_NUM_STAGES,
  parameter int BUBBLE_STAGE   = STAGE_ID,
  parameter int REDIRECT_STAGE = STAGE_ID,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_fetchValid,
  input  logic [NUM_STAGES-1:0] i_busy,
  input  logic                  i_hazard,
  input  logic                  i_redirect,
  input  logic                  i_flushAll,
  output logic [NUM_STAGES-1:0] o_valid,
  output logic [NUM_STAGES-1:0] o_stall,
  output logic [NUM_STAGES-1:0] o_flush,
  output logic                  o_redirectTaken,
  output logic                  o_retire,
  output logic [CNT_WIDTH-1:0]  o_cycleCount,
  output logic [CNT_WIDTH-1:0]  o_retireCount
);

  if (NUM_STAGES < 3 || NUM_STAGES > 8) begin : g_bad_depth
    $error("pipeline_control: NUM_STAGES out of range");
  end
  if (REDIRECT_STAGE < 1 || REDIRECT_STAGE >= NUM_STAGES-1) begin : g_bad_redirect
    $error("pipeline_control: REDIRECT_STAGE out of range");
  end

  logic [NUM_STAGES-1:0] valid;
  logic [NUM_STAGES-1:0] hold_chain;
  logic [NUM_STAGES-1:0] hold;
  logic [NUM_STAGES-1:0] flush;
  logic                  hazard_act;
  logic                  redirect_taken;

  assign valid[0]   = i_fetchValid;
  assign hazard_act = i_hazard & valid[BUBBLE_STAGE];

  // Backpressure ripples from WB toward IF; only valid stages can hold.
  always_comb begin
    logic carry;
    carry      = 1'b0;
    hold_chain = '0;
    for (int k = NUM_STAGES-1; k >= 0; k--) begin
      hold_chain[k] = valid[k] & (i_busy[k] | carry);
      carry         = hold_chain[k];
    end
  end

  always_comb begin
    hold = '0;
    for (int k = 0; k < NUM_STAGES; k++)
      hold[k] = ~i_flushAll & (hold_chain[k] | (hazard_act & (k <= BUBBLE_STAGE)));
  end

  assign redirect_taken = i_redirect & valid[REDIRECT_STAGE] & ~hold[REDIRECT_STAGE] & ~i_flushAll;

  always_comb begin
    flush = '0;
    for (int k = 1; k < NUM_STAGES; k++)
      flush[k] = ~i_reset & (i_flushAll | (redirect_taken & (k <= REDIRECT_STAGE)));
  end

  for (genvar k = 1; k < NUM_STAGES; k++) begin : g_stage
    logic valid_q, valid_d;

    always_comb begin
      valid_d = valid[k-1];
      if (flush[k])       valid_d = 1'b0;
      else if (hold[k])   valid_d = valid_q;
      else if (hold[k-1]) valid_d = 1'b0;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) valid_q <= 1'b0;
      else         valid_q <= valid_d;
    end

    assign valid[k] = valid_q;
  end

  assign o_valid         = valid;
  assign o_stall         = hold;
  assign o_flush         = flush;
  assign o_redirectTaken = redirect_taken;
  assign o_retire        = valid[NUM_STAGES-1] & ~i_busy[NUM_STAGES-1] & ~i_flushAll;

  event_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cycle_cnt (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_enable (1'b1),
    .o_count  (o_cycleCount)
  );

  event_counter #(.CNT_WIDTH(CNT_WIDTH)) u_retire_cnt (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_enable (o_retire),
    .o_count  (o_retireCount)
  );

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control: fill, hazard, redirect, busy, flush, wrap and async reset.
module tb_pipeline_control;
  import pipeline_control_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, fv, haz, redir, fa;
  StageMask   busy;
  StageMask   valid, stall, flush;
  logic       rtaken, ret;
  logic [31:0] cc, rc;
  StageMask   valid4, stall4, flush4;
  logic       rtaken4, ret4;
  logic [3:0] cc4, rc4;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  pipeline_control u_dut (
    .i_clock(clk), .i_reset(rst), .i_fetchValid(fv), .i_busy(busy),
    .i_hazard(haz), .i_redirect(redir), .i_flushAll(fa),
    .o_valid(valid), .o_stall(stall), .o_flush(flush),
    .o_redirectTaken(rtaken), .o_retire(ret),
    .o_cycleCount(cc), .o_retireCount(rc)
  );

  pipeline_control #(.CNT_WIDTH(4)) u_dut4 (
    .i_clock(clk), .i_reset(rst), .i_fetchValid(fv), .i_busy(busy),
    .i_hazard(haz), .i_redirect(redir), .i_flushAll(fa),
    .o_valid(valid4), .o_stall(stall4), .o_flush(flush4),
    .o_redirectTaken(rtaken4), .o_retire(ret4),
    .o_cycleCount(cc4), .o_retireCount(rc4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    rst = 1'b1; fv = 1'b0; haz = 1'b0; redir = 1'b0; fa = 1'b1; busy = '0;
    #12;
    chk("rst_valid",  valid,  5'b00000);
    chk("rst_flush",  flush,  5'b00000);
    chk("rst_stall",  stall,  5'b00000);
    chk("rst_cc",     cc,     0);
    chk("rst_rc",     rc,     0);
    chk("rst_ret",    ret,    0);
    chk("rst_rtaken", rtaken, 0);

    @(negedge clk);
    rst = 1'b0; fa = 1'b0; fv = 1'b1; cyc = 0;

    // free run: cycles 0..16
    for (int c = 0; c < 17; c++) begin
      #1;
      chk("fill_ret", ret, (c >= 4) ? 1 : 0);
      if (c == 10) begin
        chk("fill_cc10", cc, 10);
        chk("fill_rc10", rc, 6);
      end
      tick();
    end
    chk("run_cc17",   cc,    17);
    chk("wrap_cc4",   cc4,   1);
    chk("run_rc17",   rc,    13);
    chk("run_valid",  valid, 5'b11111);

    // load-use hazard, cycle 17
    haz = 1'b1; #1;
    chk("haz_stall", stall, 5'b00011);
    chk("haz_ret",   ret,   1);
    tick(); haz = 1'b0; #1;
    chk("haz_v18",   valid, 5'b11011);
    tick(); #1;
    chk("haz_v19",   valid, 5'b10111);
    tick(); #1;
    chk("haz_v20",   valid, 5'b01111);
    chk("haz_ret20", ret,   0);
    tick(); #1;
    chk("haz_v21",   valid, 5'b11111);
    chk("haz_ret21", ret,   1);
    tick();
    chk("haz_rc",    rc,    17);

    // redirect, cycle 22
    redir = 1'b1; #1;
    chk("rd_taken", rtaken, 1);
    chk("rd_flush", flush,  5'b00010);
    chk("rd_stall", stall,  5'b00000);
    tick(); redir = 1'b0; #1;
    chk("rd_v23",   valid,  5'b11101);
    tick(); tick(); tick(); #1;
    chk("rd_v26",   valid,  5'b01111);
    chk("rd_ret26", ret,    0);
    tick(); #1;
    chk("rd_v27",   valid,  5'b11111);
    tick();

    // MEM busy for 3 cycles, cycle 28
    busy = 5'b01000; #1;
    chk("bz_stall28", stall, 5'b01111);
    chk("bz_ret28",   ret,   1);
    tick(); #1;
    chk("bz_v29",     valid, 5'b01111);
    chk("bz_stall29", stall, 5'b01111);
    chk("bz_ret29",   ret,   0);
    tick(); #1;
    chk("bz_stall30", stall, 5'b01111);
    chk("bz_ret30",   ret,   0);
    tick(); busy = '0; #1;
    chk("bz_v31",     valid, 5'b01111);
    chk("bz_stall31", stall, 5'b00000);
    tick(); #1;
    chk("bz_v32",     valid, 5'b11111);
    tick();
    chk("bz_rc33",    rc,    24);
    chk("bz_cc33",    cc,    33);

    // trap flush with redirect and hazard pending, cycle 33
    fa = 1'b1; redir = 1'b1; haz = 1'b1; #1;
    chk("fa_taken", rtaken, 0);
    chk("fa_flush", flush,  5'b11110);
    chk("fa_stall", stall,  5'b00000);
    chk("fa_ret",   ret,    0);
    tick(); fa = 1'b0; redir = 1'b0; haz = 1'b0; busy = 5'b11110; #1;
    chk("fa_v34",    valid, 5'b00001);
    chk("inv_busy",  stall, 5'b00000);
    tick(); busy = '0; haz = 1'b1; redir = 1'b1; #1;
    chk("hr_v35",     valid,  5'b00011);
    chk("hr_stall",   stall,  5'b00011);
    chk("hr_taken",   rtaken, 0);
    chk("hr_flush",   flush,  5'b00000);
    tick(); haz = 1'b0; redir = 1'b0;

    // async reset mid-cycle
    #2; rst = 1'b1; #1;
    chk("ar_valid", valid[4:1], 4'b0000);
    chk("ar_cc",    cc,  0);
    chk("ar_rc",    rc,  0);
    chk("ar_cc4",   cc4, 0);
    tick(); tick();
    rst = 1'b0; cyc = 0;
    tick(); tick(); tick();
    chk("rr_cc",    cc,    3);
    chk("rr_valid", valid, 5'b01111);
    chk("rr_rc",    rc,    0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
